// File: rtl/cla_sub12_if.sv
// Operand/result bundle for the 12-bit pipelined subtractor.
// The master side supplies operands and accepts results; the slave side is the subtractor.
interface cla_sub12_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, diff, bout, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, diff, bout, ovf, zero, out_valid
  );
endinterface

// File: rtl/cla_sub12_pipe.sv
// 12-bit subtractor a - b - bin, computed as a + ~b + ~bin with one 4-bit lookahead
// slice per pipeline stage; stall-all valid/ready pipeline with registered flags.
module cla_sub12_pipe #(
  parameter int WIDTH  = 12,
  parameter int SLICE  = 4,
  parameter int STAGES = 3
) (
  input logic         clk,
  input logic         rst_n,
  cla_sub12_if.slave  bus
);

  localparam int LAST = STAGES - 1;

  // Every carry in the slice is a sum of products of g/p and the slice carry-in,
  // so no carry depends on another carry inside the slice.
  function automatic logic [SLICE:0] lookahead(input logic [SLICE-1:0] g,
                                               input logic [SLICE-1:0] p,
                                               input logic             cin);
    logic [SLICE:0] c;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             adv;
  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] part_q  [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES-1];
  logic [WIDTH-1:0] opb_q   [STAGES-1];
  logic             cy_q    [STAGES-1];
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] opa_src [STAGES];
  logic [WIDTH-1:0] opb_src [STAGES];
  logic [WIDTH-1:0] part_src[STAGES];
  logic             cin_src [STAGES];
  logic             vld_src [STAGES];
  logic [SLICE-1:0] g_d     [STAGES];
  logic [SLICE-1:0] p_d     [STAGES];
  logic [SLICE:0]   c_d     [STAGES];
  logic [WIDTH-1:0] part_d  [STAGES];

  assign adv          = ~vld_q[LAST] | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    opa_src[0]  = bus.a;
    opb_src[0]  = bus.b;
    part_src[0] = '0;
    cin_src[0]  = ~bus.bin;
    vld_src[0]  = bus.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      opa_src[s]  = opa_q[s-1];
      opb_src[s]  = opb_q[s-1];
      part_src[s] = part_q[s-1];
      cin_src[s]  = cy_q[s-1];
      vld_src[s]  = vld_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      g_d[s]    = opa_src[s][s*SLICE +: SLICE] & ~opb_src[s][s*SLICE +: SLICE];
      p_d[s]    = opa_src[s][s*SLICE +: SLICE] ^ ~opb_src[s][s*SLICE +: SLICE];
      c_d[s]    = lookahead(g_d[s], p_d[s], cin_src[s]);
      part_d[s] = part_src[s];
      part_d[s][s*SLICE +: SLICE] = p_d[s] ^ c_d[s][SLICE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        part_q[s] <= '0;
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        opa_q[s] <= '0;
        opb_q[s] <= '0;
        cy_q[s]  <= 1'b0;
      end
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]  <= vld_src[s];
        part_q[s] <= part_d[s];
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        opa_q[s] <= opa_src[s];
        opb_q[s] <= opb_src[s];
        cy_q[s]  <= c_d[s][SLICE];
      end
      // Flags are resolved in the last stage so the outputs come straight from flops.
      bout_q <= ~c_d[LAST][SLICE];
      ovf_q  <= c_d[LAST][SLICE] ^ c_d[LAST][SLICE-1];
      zero_q <= ~|part_d[LAST];
    end
  end

  assign bus.diff      = part_q[LAST];
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = vld_q[LAST];

endmodule

// File: tb/tb_cla_sub12_pipe.sv
// Self-checking bench for cla_sub12_pipe: directed corner vectors, backpressure,
// mid-flight reset and a throttled random sweep against an arithmetic reference.
module tb_cla_sub12_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cla_sub12_if #(.WIDTH(12)) sif ();

  cla_sub12_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [14:0] exp_q[$];

  // Observations taken 1 ns after the falling edge, before the next rising edge.
  logic        o_ir;
  logic        o_ov;
  logic [14:0] o_res;

  // Reference result packed as {zero, ovf, bout, diff}.
  function automatic logic [14:0] ref_sub(input logic [11:0] a, input logic [11:0] b,
                                          input logic bin);
    int          ua, ub, sa, sb, r;
    logic [11:0] d;
    logic        bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2048) ? ua - 4096 : ua;
    sb = (ub >= 2048) ? ub - 4096 : ub;
    d  = 12'(ua - ub - int'(bin));
    bo = (ua < ub + int'(bin));
    r  = sa - sb - int'(bin);
    ov = (r > 2047) || (r < -2048);
    return {(d == 12'd0), ov, bo, d};
  endfunction

  task automatic step(input logic [11:0] a, input logic [11:0] b, input logic bin,
                      input logic iv, input logic ordy);
    @(negedge clk);
    sif.a         = a;
    sif.b         = b;
    sif.bin       = bin;
    sif.in_valid  = iv;
    sif.out_ready = ordy;
    #1;
    o_ir  = sif.in_ready;
    o_ov  = sif.out_valid;
    o_res = {sif.zero, sif.ovf, sif.bout, sif.diff};
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({sif.out_valid, sif.zero, sif.ovf, sif.bout, sif.diff} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=0000",
               {sif.out_valid, sif.zero, sif.ovf, sif.bout, sif.diff});
    end
    n_vec++;
    if (sif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b want=1", sif.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (o_ov !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_valid got=%b want=0", o_ov);
    end
  endtask

  task automatic test_directed();
    logic [11:0] va  [6];
    logic [11:0] vb  [6];
    logic        vc  [6];
    logic [14:0] vr  [6];
    va = '{12'h000, 12'h800, 12'h7FF, 12'h5A5, 12'h100, 12'h000};
    vb = '{12'h001, 12'h001, 12'hFFF, 12'h5A5, 12'h0FF, 12'h000};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // {zero, ovf, bout, diff}
    vr = '{{3'b001, 12'hFFF}, {3'b010, 12'h7FF}, {3'b011, 12'h800},
           {3'b100, 12'h000}, {3'b100, 12'h000}, {3'b001, 12'hFFF}};
    for (int v = 0; v < 6; v++) begin
      step(va[v], vb[v], vc[v], 1'b1, 1'b1);
      n_vec++;
      if (o_ir !== 1'b1) begin
        n_bad++;
        $display("FAIL dir%0d_accept got=%b want=1", v, o_ir);
      end
      for (int k = 1; k <= 4; k++) begin
        step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (o_ov !== (k == 3)) begin
          n_bad++;
          $display("FAIL dir%0d_valid_cycle%0d got=%b want=%b", v, k, o_ov, (k == 3));
        end
        if (k == 3) begin
          n_vec++;
          if (o_res !== vr[v]) begin
            n_bad++;
            $display("FAIL dir%0d_result got zfb/diff=%h want=%h", v, o_res, vr[v]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] oa [5];
    logic [11:0] ob [5];
    logic        oc [5];
    int          idx = 0;
    int          got = 0;
    logic        iv, ordy;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      oa[i] = 12'($urandom);
      ob[i] = 12'($urandom);
      oc[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      iv   = (idx < 5);
      ordy = !(cyc == 3 || cyc == 4);
      step(iv ? oa[idx % 5] : 12'h0, iv ? ob[idx % 5] : 12'h0, iv ? oc[idx % 5] : 1'b0,
           iv, ordy);
      if (cyc < 5) begin
        n_vec++;
        if (o_ir !== (cyc < 3)) begin
          n_bad++;
          $display("FAIL b2b_in_ready_cyc%0d got=%b want=%b", cyc, o_ir, (cyc < 3));
        end
      end
      if (cyc == 3 || cyc == 4) begin
        n_vec++;
        if (o_ov !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_held_valid_cyc%0d got=%b want=1", cyc, o_ov);
        end
      end
      if (o_ov === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_spurious_result got=%h want=none", o_res);
        end else begin
          if (o_res !== exp_q[0]) begin
            n_bad++;
            $display("FAIL b2b_result got=%h want=%h", o_res, exp_q[0]);
          end
          if (ordy) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (iv && o_ir === 1'b1) begin
        exp_q.push_back(ref_sub(oa[idx], ob[idx], oc[idx]));
        idx++;
      end
    end
    n_vec++;
    if (got != 5 || idx != 5 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_delivery got=%0d sent=%0d pending=%0d want=5/5/0",
               got, idx, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    step(12'h123, 12'h045, 1'b0, 1'b1, 1'b0);
    step(12'h456, 12'h789, 1'b1, 1'b1, 1'b0);
    step(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    #1;
    n_vec++;
    if (sif.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midflight_pre_valid got=%b want=1", sif.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({sif.out_valid, sif.zero, sif.ovf, sif.bout, sif.diff} !== 16'h0) begin
      n_bad++;
      $display("FAIL midflight_async_clear got=%h want=0000",
               {sif.out_valid, sif.zero, sif.ovf, sif.bout, sif.diff});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (sif.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midflight_held_valid got=%b want=0", sif.out_valid);
    end
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (o_ov !== 1'b0) begin
        n_bad++;
        $display("FAIL midflight_ghost_cyc%0d got=%b want=0", i, o_ov);
      end
    end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          cyc  = 0;
    logic [11:0] ra, rb;
    logic        rbin, riv, rrdy;
    do_reset();
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      riv  = (sent < 10000) && ($urandom_range(0, 9) < 8);
      rrdy = (sent >= 10000) || ($urandom_range(0, 3) != 0);
      ra   = 12'($urandom);
      rb   = 12'($urandom);
      rbin = 1'($urandom_range(0, 1));
      step(ra, rb, rbin, riv, rrdy);
      cyc++;
      if (o_ov === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_spurious_result got=%h want=none", o_res);
        end else begin
          if (o_res !== exp_q[0]) begin
            n_bad++;
            $display("FAIL rand_result got=%h want=%h", o_res, exp_q[0]);
          end
          if (rrdy) void'(exp_q.pop_front());
        end
      end
      if (riv && o_ir === 1'b1) begin
        exp_q.push_back(ref_sub(ra, rb, rbin));
        sent++;
      end
    end
    n_vec++;
    if (sent != 10000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_completion got sent=%0d pending=%0d want=10000/0",
               sent, exp_q.size());
    end
  endtask

  initial begin
    sif.a         = '0;
    sif.b         = '0;
    sif.bin       = 1'b0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
